// File: rtl/mcast_feeder.sv
// mcast_feeder: loads cluster multicast ID chains, then streams tagged weights/acts.
// Define MCAST_FEEDER_ID_SCAN_EN to build the ID scan/latch phase.
module mcast_feeder #(
  parameter int numPeX   = 3,
  parameter int numPeY   = 3,
  parameter int dataSize = 8,
  parameter int addrSize = 16,
  parameter int idSize   = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start_i,
  input  logic [7:0]            ctrl_wcount,
  input  logic [7:0]            ctrl_acount,
  input  logic [addrSize-1:0]   cfg_w_base,
  input  logic [addrSize-1:0]   cfg_a_base,
  input  logic [idSize-1:0]     cfg_w_tags_x,
  input  logic [idSize-1:0]     cfg_w_tags_y,
  input  logic [idSize-1:0]     cfg_a_tags_x,
  input  logic [idSize-1:0]     cfg_a_tags_y,
  output logic [addrSize-1:0]   id_addr_o,
  input  logic [2*idSize-1:0]   id_data_i,
  output logic [addrSize-1:0]   w_rd_addr_o,
  output logic [addrSize-1:0]   a_rd_addr_o,
  input  logic [dataSize-1:0]   w_rd_data_i,
  input  logic [dataSize-1:0]   a_rd_data_i,
  output logic [dataSize-1:0]   w_data_o,
  output logic [dataSize-1:0]   a_data_o,
  output logic [idSize-1:0]     weight_tag_x_o,
  output logic [idSize-1:0]     weight_tag_y_o,
  output logic [idSize-1:0]     act_tag_x_o,
  output logic [idSize-1:0]     act_tag_y_o,
  output logic [idSize-1:0]     act_id_scan_o,
  output logic [idSize-1:0]     weight_id_scan_o,
  output logic                  act_id_wren_o,
  output logic                  weight_id_wren_o,
  output logic                  cluster_enable_o,
  output logic                  start_compute_o,
  input  logic                  flag_done_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int N = numPeX * numPeY + numPeY;
  localparam logic [idSize-1:0] NO_TGT = '1;
  localparam logic [idSize-1:0] ONE_ID = 1;
  localparam logic [addrSize-1:0] ONE_A = 1;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef MCAST_FEEDER_ID_SCAN_EN
    S_SCAN,
    S_LATCH,
`endif
    S_LOADW,
    S_LOADA,
    S_START,
    S_WAIT
  } state_t;

  state_t state, nxt, load_st;

  logic [7:0] wc, ac;
  logic [idSize-1:0] wtx, wty, atx, aty;
  logic w_empty, a_empty, w_last, a_last;
  logic start_ph;

  assign w_empty = ctrl_wcount == 8'd0 || cfg_w_tags_x == '0
                || cfg_w_tags_y == '0;
  assign a_empty = ctrl_acount == 8'd0 || cfg_a_tags_x == '0
                || cfg_a_tags_y == '0;
  assign w_last = wc == ctrl_wcount - 8'd1
               && wtx == cfg_w_tags_x - ONE_ID
               && wty == cfg_w_tags_y - ONE_ID;
  assign a_last = ac == ctrl_acount - 8'd1
               && atx == cfg_a_tags_x - ONE_ID
               && aty == cfg_a_tags_y - ONE_ID;
  assign load_st = w_empty ? (a_empty ? S_START : S_LOADA) : S_LOADW;

`ifdef MCAST_FEEDER_ID_SCAN_EN
  // two extra scan cycles drain the ID table read and scan register
  localparam int CW = $clog2(N + 2);
  logic [CW-1:0] scnt;
  logic scan_v;
  logic scan_rd;

  assign scan_rd = state == S_SCAN && scnt < CW'(N);
  assign id_addr_o = scan_rd ? addrSize'(scnt) : '0;
  assign act_id_wren_o = state == S_LATCH;
  assign weight_id_wren_o = state == S_LATCH;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      scnt <= '0;
      scan_v <= 1'b0;
      act_id_scan_o <= '0;
      weight_id_scan_o <= '0;
    end else begin
      scan_v <= scan_rd;
      if (state != S_SCAN) scnt <= '0;
      else scnt <= scnt + CW'(1);
      if (scan_v) begin
        weight_id_scan_o <= id_data_i[2*idSize-1:idSize];
        act_id_scan_o <= id_data_i[idSize-1:0];
      end
    end
  end
`else
  logic unused_id;
  assign unused_id = ^id_data_i;
  assign id_addr_o = '0;
  assign act_id_scan_o = '0;
  assign weight_id_scan_o = '0;
  assign act_id_wren_o = 1'b0;
  assign weight_id_wren_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start_i) begin
`ifdef MCAST_FEEDER_ID_SCAN_EN
        nxt = S_SCAN;
`else
        nxt = load_st;
`endif
      end
`ifdef MCAST_FEEDER_ID_SCAN_EN
      S_SCAN:  if (scnt == CW'(N + 1)) nxt = S_LATCH;
      S_LATCH: nxt = load_st;
`endif
      S_LOADW: if (w_last) nxt = a_empty ? S_START : S_LOADA;
      S_LOADA: if (a_last) nxt = S_START;
      S_START: if (start_ph) nxt = S_WAIT;
      S_WAIT:  if (flag_done_i) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign busy_o = state != S_IDLE;
  assign cluster_enable_o = state != S_IDLE;
  assign start_compute_o = state == S_START && start_ph;
  assign w_data_o = w_rd_data_i;
  assign a_data_o = a_rd_data_i;

  // first S_START cycle covers the last word's data cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      w_rd_addr_o <= '0;
      a_rd_addr_o <= '0;
      wc <= '0;
      wtx <= '0;
      wty <= '0;
      ac <= '0;
      atx <= '0;
      aty <= '0;
      weight_tag_x_o <= NO_TGT;
      weight_tag_y_o <= NO_TGT;
      act_tag_x_o <= NO_TGT;
      act_tag_y_o <= NO_TGT;
      start_ph <= 1'b0;
      done_o <= 1'b0;
    end else begin
      weight_tag_x_o <= NO_TGT;
      weight_tag_y_o <= NO_TGT;
      act_tag_x_o <= NO_TGT;
      act_tag_y_o <= NO_TGT;
      start_ph <= state == S_START && !start_ph;
      done_o <= state == S_WAIT && flag_done_i;
      if (state != S_LOADW && nxt == S_LOADW) begin
        w_rd_addr_o <= cfg_w_base;
        wc <= '0;
        wtx <= '0;
        wty <= '0;
      end else if (state == S_LOADW) begin
        weight_tag_x_o <= wtx;
        weight_tag_y_o <= wty;
        if (!w_last) w_rd_addr_o <= w_rd_addr_o + ONE_A;
        if (wc == ctrl_wcount - 8'd1) begin
          wc <= '0;
          if (wtx == cfg_w_tags_x - ONE_ID) begin
            wtx <= '0;
            wty <= wty + ONE_ID;
          end else wtx <= wtx + ONE_ID;
        end else wc <= wc + 8'd1;
      end
      if (state != S_LOADA && nxt == S_LOADA) begin
        a_rd_addr_o <= cfg_a_base;
        ac <= '0;
        atx <= '0;
        aty <= '0;
      end else if (state == S_LOADA) begin
        act_tag_x_o <= atx;
        act_tag_y_o <= aty;
        if (!a_last) a_rd_addr_o <= a_rd_addr_o + ONE_A;
        if (ac == ctrl_acount - 8'd1) begin
          ac <= '0;
          if (atx == cfg_a_tags_x - ONE_ID) begin
            atx <= '0;
            aty <= aty + ONE_ID;
          end else atx <= atx + ONE_ID;
        end else ac <= ac + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mcast_feeder.sv
// tb_mcast_feeder: per-cycle check of mcast_feeder against a word-list model.
// Works with or without MCAST_FEEDER_ID_SCAN_EN defined.
module tb_mcast_feeder;

  localparam int NX = 3;
  localparam int NY = 3;
  localparam int N = NX * NY + NY;
`ifdef MCAST_FEEDER_ID_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  tx;
    logic [7:0]  ty;
  } word_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start_i = 1'b0;
  logic [7:0] ctrl_wcount = '0, ctrl_acount = '0;
  logic [15:0] cfg_w_base = '0, cfg_a_base = '0;
  logic [7:0] cfg_w_tags_x = '0, cfg_w_tags_y = '0;
  logic [7:0] cfg_a_tags_x = '0, cfg_a_tags_y = '0;
  logic [15:0] id_addr_o;
  logic [15:0] id_data_i;
  logic [15:0] w_rd_addr_o, a_rd_addr_o;
  logic [7:0] w_rd_data_i, a_rd_data_i;
  logic [7:0] w_data_o, a_data_o;
  logic [7:0] weight_tag_x_o, weight_tag_y_o, act_tag_x_o, act_tag_y_o;
  logic [7:0] act_id_scan_o, weight_id_scan_o;
  logic act_id_wren_o, weight_id_wren_o;
  logic cluster_enable_o, start_compute_o;
  logic flag_done_i = 1'b0;
  logic busy_o, done_o;

  logic [7:0] wmem [65536];
  logic [7:0] amem [65536];
  logic [15:0] idtab [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    w_rd_data_i <= wmem[w_rd_addr_o];
    a_rd_data_i <= amem[a_rd_addr_o];
    id_data_i <= idtab[id_addr_o[7:0]];
  end

  mcast_feeder dut (
    .clk(clk), .nrst(nrst), .start_i(start_i),
    .ctrl_wcount(ctrl_wcount), .ctrl_acount(ctrl_acount),
    .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base),
    .cfg_w_tags_x(cfg_w_tags_x), .cfg_w_tags_y(cfg_w_tags_y),
    .cfg_a_tags_x(cfg_a_tags_x), .cfg_a_tags_y(cfg_a_tags_y),
    .id_addr_o(id_addr_o), .id_data_i(id_data_i),
    .w_rd_addr_o(w_rd_addr_o), .a_rd_addr_o(a_rd_addr_o),
    .w_rd_data_i(w_rd_data_i), .a_rd_data_i(a_rd_data_i),
    .w_data_o(w_data_o), .a_data_o(a_data_o),
    .weight_tag_x_o(weight_tag_x_o), .weight_tag_y_o(weight_tag_y_o),
    .act_tag_x_o(act_tag_x_o), .act_tag_y_o(act_tag_y_o),
    .act_id_scan_o(act_id_scan_o), .weight_id_scan_o(weight_id_scan_o),
    .act_id_wren_o(act_id_wren_o), .weight_id_wren_o(weight_id_wren_o),
    .cluster_enable_o(cluster_enable_o), .start_compute_o(start_compute_o),
    .flag_done_i(flag_done_i), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_w_addr", w_rd_addr_o, 0);
    check("rst_a_addr", a_rd_addr_o, 0);
    check("rst_id_addr", id_addr_o, 0);
    check("rst_w_scan", weight_id_scan_o, 0);
    check("rst_a_scan", act_id_scan_o, 0);
    check("rst_w_tx", weight_tag_x_o, 8'hFF);
    check("rst_w_ty", weight_tag_y_o, 8'hFF);
    check("rst_a_tx", act_tag_x_o, 8'hFF);
    check("rst_a_ty", act_tag_y_o, 8'hFF);
    check("rst_wrens", {act_id_wren_o, weight_id_wren_o}, 0);
    check("rst_busy", busy_o, 0);
    check("rst_enable", cluster_enable_o, 0);
    check("rst_done", done_o, 0);
    check("rst_start", start_compute_o, 0);
  endtask

  task automatic apply_cfg(input int wc, ac, wtx, wty, atx, aty,
                           input logic [15:0] wb, ab);
    ctrl_wcount = 8'(wc);
    ctrl_acount = 8'(ac);
    cfg_w_tags_x = 8'(wtx);
    cfg_w_tags_y = 8'(wty);
    cfg_a_tags_x = 8'(atx);
    cfg_a_tags_y = 8'(aty);
    cfg_w_base = wb;
    cfg_a_base = ab;
  endtask

  // Called #1 after a clock edge with the DUT idle.
  task automatic run_pass(input int wc, ac, wtx, wty, atx, aty,
                          input logic [15:0] wb, ab, input int dly);
    word_t wq[$];
    word_t aq[$];
    int so, nw, na, sc, f, j;
    logic [7:0] etx, ety, edat;
    for (int ty = 0; ty < wty; ty++)
      for (int tx = 0; tx < wtx; tx++)
        for (int i = 0; i < wc; i++)
          wq.push_back('{16'(wb + wq.size()), 8'(tx), 8'(ty)});
    for (int ty = 0; ty < aty; ty++)
      for (int tx = 0; tx < atx; tx++)
        for (int i = 0; i < ac; i++)
          aq.push_back('{16'(ab + aq.size()), 8'(tx), 8'(ty)});
    nw = wq.size();
    na = aq.size();
    so = SCAN ? N + 3 : 0;
    sc = so + nw + na + 2;
    f = sc + 1 + dly;
    apply_cfg(wc, ac, wtx, wty, atx, aty, wb, ab);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= f + 2; c++) begin
      flag_done_i = (c == f) || (c == 1);
      start_i = (c == sc + 1);
      check("busy", busy_o, c <= f);
      check("enable", cluster_enable_o, c <= f);
      check("done", done_o, c == f + 1);
      check("start_compute", start_compute_o, c == sc);
      check("wrens", {act_id_wren_o, weight_id_wren_o},
            (SCAN && c == N + 3) ? 2'b11 : 2'b00);
      check("id_addr", id_addr_o,
            (SCAN && c <= N) ? 32'(c - 1) : 0);
      if (!SCAN || (c >= 3 && c <= N + 2)) begin
        check("w_scan", weight_id_scan_o,
              SCAN ? idtab[c-3][15:8] : 8'h00);
        check("a_scan", act_id_scan_o,
              SCAN ? idtab[c-3][7:0] : 8'h00);
      end
      if (c >= so + 1 && c <= so + nw)
        check("w_addr", w_rd_addr_o, wq[c-so-1].addr);
      if (c >= so + nw + 1 && c <= so + nw + na)
        check("a_addr", a_rd_addr_o, aq[c-so-nw-1].addr);
      etx = 8'hFF;
      ety = 8'hFF;
      if (c >= so + 2 && c <= so + nw + 1) begin
        j = c - so - 2;
        etx = wq[j].tx;
        ety = wq[j].ty;
        edat = wmem[wq[j].addr];
        check("w_data", w_data_o, edat);
      end
      check("w_tag_x", weight_tag_x_o, etx);
      check("w_tag_y", weight_tag_y_o, ety);
      etx = 8'hFF;
      ety = 8'hFF;
      if (c >= so + nw + 2 && c <= so + nw + na + 1) begin
        j = c - so - nw - 2;
        etx = aq[j].tx;
        ety = aq[j].ty;
        edat = amem[aq[j].addr];
        check("a_data", a_data_o, edat);
      end
      check("a_tag_x", act_tag_x_o, etx);
      check("a_tag_y", act_tag_y_o, ety);
      @(posedge clk);
      #1;
    end
    flag_done_i = 1'b0;
    start_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      wmem[i] = 8'($urandom);
      amem[i] = 8'($urandom);
    end
    for (int k = 0; k < 256; k++) idtab[k] = {8'(k), 8'(k)};
    #7;
    check_reset();
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // identity IDs; 2 words x 3 x-tags; no activations; long wait
    run_pass(2, 0, 3, 1, 1, 1, 16'h0010, 16'h0200, 20);

    for (int k = 0; k < 256; k++) idtab[k] = 16'($urandom);
    run_pass(1, 2, 2, 2, 3, 1, 16'hFFFE, 16'h1234, 0);
    run_pass(0, 3, 2, 2, 2, 1, 16'h0100, 16'hFFFD, 3);
    run_pass(0, 0, 1, 1, 1, 1, 16'h0040, 16'h0050, 1);
    run_pass(3, 2, 1, 2, 2, 2, 16'h7000, 16'h8000, 2);
    for (int p = 0; p < 3; p++)
      run_pass($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3),
               16'($urandom), 16'($urandom), $urandom_range(0, 6));

    // reset while the weight stream is running, then a clean pass
    apply_cfg(2, 2, 3, 1, 2, 1, 16'h0300, 16'h0400);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat ((SCAN ? N + 3 : 0) + 2) @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", busy_o, 0);
    run_pass(2, 2, 3, 1, 2, 1, 16'h0300, 16'h0400, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
